// File: rtl/evr_heartbeat_gen_if.sv
// CSR write/status port of the EVR heartbeat generator.
// The master drives the write strobe and data word; the slave returns status.
interface evr_heartbeat_gen_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 csrStrobe;
  logic [BUS_WIDTH-1:0] csrData;
  logic [BUS_WIDTH-1:0] csrStatus;

  modport master (output csrStrobe, output csrData, input csrStatus);
  modport slave  (input csrStrobe, input csrData, output csrStatus);
endinterface

// File: rtl/evr_heartbeat_gen.sv
// Local EVR heartbeat source: periodic fixed-width pulse with programmable period,
// one-pulse skip, single-shot and phase restart, all in the evrClk domain.
module evr_heartbeat_gen #(
  parameter int BUS_WIDTH      = 32,
  parameter int PERIOD_WIDTH   = 28,
  parameter int PULSE_WIDTH    = 4,
  parameter int DEFAULT_RELOAD = 124999
) (
  input  logic                 evrClk,
  input  logic                 evrReset,
  evr_heartbeat_gen_if.slave   csr,
  output logic                 evrHeartbeat,
  output logic [15:0]          beatCount
);
  localparam int SW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [PERIOD_WIDTH-1:0] MIN_RELOAD   = PERIOD_WIDTH'(PULSE_WIDTH);
  localparam logic [PERIOD_WIDTH-1:0] RST_RELOAD   = PERIOD_WIDTH'(DEFAULT_RELOAD);
  localparam logic [SW-1:0]           STRETCH_INIT = SW'(PULSE_WIDTH - 1);

  // registered state
  logic                    enabled, skip_pending, shot_pending;
  logic [SW-1:0]           stretch;
  logic [PERIOD_WIDTH-1:0] counter, reload;

  // next-state values
  logic                    enabled_nxt, skip_nxt, shot_nxt, hb_nxt;
  logic [SW-1:0]           stretch_nxt;
  logic [PERIOD_WIDTH-1:0] counter_nxt, reload_nxt;
  logic [15:0]             beat_nxt;

  // write word decode
  logic                    wr, wr_en, wr_skip, wr_shot, wr_restart;
  logic [PERIOD_WIDTH-1:0] wr_raw, wr_reload;

  assign wr         = csr.csrStrobe;
  assign wr_en      = csr.csrData[BUS_WIDTH-1];
  assign wr_skip    = csr.csrData[BUS_WIDTH-2];
  assign wr_shot    = csr.csrData[BUS_WIDTH-3];
  assign wr_restart = csr.csrData[BUS_WIDTH-4];
  assign wr_raw     = csr.csrData[PERIOD_WIDTH-1:0];
  // Clamping keeps at least one low cycle per period, so every beat is a fresh edge.
  assign wr_reload  = (wr_raw < MIN_RELOAD) ? MIN_RELOAD : wr_raw;

  logic dis_wr, ena_wr, rst_wr, wrap, fire;
  logic [PERIOD_WIDTH-1:0] eff_reload;

  always_comb begin
    enabled_nxt = enabled;
    skip_nxt    = skip_pending;
    shot_nxt    = shot_pending;
    hb_nxt      = evrHeartbeat;
    stretch_nxt = stretch;
    counter_nxt = counter;
    reload_nxt  = reload;
    beat_nxt    = beatCount;
    fire        = 1'b0;

    dis_wr     = wr & ~wr_en;
    ena_wr     = wr & wr_en & ~enabled;
    rst_wr     = wr & wr_en & enabled & wr_restart;
    eff_reload = wr ? wr_reload : reload;
    wrap       = enabled & ~dis_wr & (counter == '0);

    // A write landing on the wrap edge supplies the value reloaded there.
    if (ena_wr || rst_wr)
      counter_nxt = wr_reload;
    else if (enabled && !dis_wr)
      counter_nxt = wrap ? eff_reload : counter - PERIOD_WIDTH'(1);

    if (wrap) begin
      if (skip_pending) skip_nxt = 1'b0;
      else              fire     = 1'b1;
    end

    if (shot_pending) begin
      fire     = 1'b1;
      shot_nxt = 1'b0;
    end

    if (stretch != '0) stretch_nxt = stretch - SW'(1);
    else               hb_nxt      = 1'b0;

    if (dis_wr) begin
      hb_nxt      = 1'b0;
      stretch_nxt = '0;
    end

    if (fire) begin
      hb_nxt      = 1'b1;
      stretch_nxt = STRETCH_INIT;
      beat_nxt    = beatCount + 16'd1;
    end

    if (wr) begin
      reload_nxt  = wr_reload;
      enabled_nxt = wr_en;
      if (wr_en && wr_skip) skip_nxt = 1'b1;
      else if (!wr_en)      skip_nxt = 1'b0;
      // single-shot only from the disabled state and never on top of a live pulse
      if (wr_shot && !wr_en && !evrHeartbeat && !shot_pending) shot_nxt = 1'b1;
    end
  end

  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      enabled      <= 1'b0;
      skip_pending <= 1'b0;
      shot_pending <= 1'b0;
      evrHeartbeat <= 1'b0;
      stretch      <= '0;
      counter      <= '0;
      reload       <= RST_RELOAD;
      beatCount    <= '0;
    end else begin
      enabled      <= enabled_nxt;
      skip_pending <= skip_nxt;
      shot_pending <= shot_nxt;
      evrHeartbeat <= hb_nxt;
      stretch      <= stretch_nxt;
      counter      <= counter_nxt;
      reload       <= reload_nxt;
      beatCount    <= beat_nxt;
    end
  end

  always_comb begin
    csr.csrStatus                    = '0;
    csr.csrStatus[BUS_WIDTH-1]       = enabled;
    csr.csrStatus[BUS_WIDTH-2]       = skip_pending;
    csr.csrStatus[BUS_WIDTH-3]       = evrHeartbeat;
    csr.csrStatus[PERIOD_WIDTH-1:0]  = reload;
  end
endmodule

// File: tb/tb_evr_heartbeat_gen.sv
// Self-checking bench for evr_heartbeat_gen: directed scenarios plus random CSR
// writes, all compared each cycle against a deadline-based reference model.
module tb_evr_heartbeat_gen;
  localparam int PW = 4;
  localparam logic [31:0] EN   = 32'h8000_0000;
  localparam logic [31:0] SKIP = 32'h4000_0000;
  localparam logic [31:0] SHOT = 32'h2000_0000;
  localparam logic [31:0] RST  = 32'h1000_0000;

  logic        evrClk = 1'b0;
  logic        evrReset;
  logic        evrHeartbeat;
  logic [15:0] beatCount;

  evr_heartbeat_gen_if #(.BUS_WIDTH(32)) csr ();

  evr_heartbeat_gen #(
    .BUS_WIDTH(32), .PERIOD_WIDTH(28), .PULSE_WIDTH(PW), .DEFAULT_RELOAD(124999)
  ) dut (
    .evrClk      (evrClk),
    .evrReset    (evrReset),
    .csr         (csr),
    .evrHeartbeat(evrHeartbeat),
    .beatCount   (beatCount)
  );

  always #5 evrClk = ~evrClk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: absolute edge deadlines rather than counters.
  int cyc;
  bit m_en, m_skip, m_hb;
  int m_reload, m_next, m_rise, m_shot_at, m_beats;

  function automatic int clampr(input int r);
    return (r < PW) ? PW : r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_skip = 0; m_hb = 0; m_reload = 124999;
    m_next = -1; m_rise = -1000; m_shot_at = -1; m_beats = 0;
  endtask

  task automatic model_edge(input bit w, input logic [31:0] d);
    int nr;
    bit shot_now, dis;
    nr       = clampr(int'(d[27:0]));
    shot_now = (m_shot_at == cyc);
    dis      = w && !d[31];
    if (m_en && !dis && cyc == m_next) begin
      m_next = cyc + (w ? nr : m_reload) + 1;
      if (m_skip) m_skip = 0;
      else begin m_rise = cyc; m_beats++; end
    end
    if (w) begin
      if (d[31] && (!m_en || d[28])) m_next = cyc + nr + 1;
      if (d[31] && d[30]) m_skip = 1;
      else if (!d[31])    m_skip = 0;
      if (dis) m_rise = -1000;
      if (d[29] && !d[31] && !m_hb && !shot_now) m_shot_at = cyc + 1;
      m_en = d[31];
      m_reload = nr;
    end
    if (shot_now) begin m_rise = cyc; m_beats++; end
    m_hb = (cyc >= m_rise) && (cyc < m_rise + PW);
  endtask

  function automatic logic [31:0] exp_status();
    return {m_en, m_skip, m_hb, 1'b0, 28'(m_reload)};
  endfunction

  task automatic tick(input bit w, input logic [31:0] d);
    csr.csrStrobe = w;
    csr.csrData   = d;
    @(posedge evrClk);
    model_edge(w, d);
    cyc++;
    #1;
    csr.csrStrobe = 1'b0;
    csr.csrData   = '0;
    chk("heartbeat", {31'b0, evrHeartbeat}, {31'b0, m_hb});
    chk("beatCount", {16'b0, beatCount}, 32'(m_beats & 32'hFFFF));
    chk("status", csr.csrStatus, exp_status());
  endtask

  task automatic wait_rise(output int k);
    bit prev;
    k = 0;
    do begin
      prev = evrHeartbeat;
      tick(1'b0, '0);
      k++;
    end while (!(evrHeartbeat && !prev) && k < 200);
    chk("rise_seen", {31'b0, evrHeartbeat & ~prev}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [15:0] b;
    logic [31:0] d;
    evrReset = 1'b1;
    csr.csrStrobe = 1'b0;
    csr.csrData = '0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge evrClk);
    #1 evrReset = 1'b0;
    #1;
    chk("rst_hb", {31'b0, evrHeartbeat}, 32'd0);
    chk("rst_beat", {16'b0, beatCount}, 32'd0);
    chk("rst_status", csr.csrStatus, 32'h0001_E847);

    // periodic: enable reload=9 at edge N
    tick(1'b1, EN | 32'd9);
    repeat (9) tick(1'b0, '0);
    chk("per_pre_rise", {31'b0, evrHeartbeat}, 32'd0);
    tick(1'b0, '0);
    chk("per_rise_n10", {31'b0, evrHeartbeat}, 32'd1);
    repeat (3) tick(1'b0, '0);
    chk("per_high4", {31'b0, evrHeartbeat}, 32'd1);
    tick(1'b0, '0);
    chk("per_fall", {31'b0, evrHeartbeat}, 32'd0);
    repeat (16) tick(1'b0, '0);
    chk("per_beat3", {16'b0, beatCount}, 32'd3);

    // skip: next beat (N+40) suppressed, N+50 on original phase
    tick(1'b1, EN | SKIP | 32'd9);
    chk("skip_set", {31'b0, csr.csrStatus[30]}, 32'd1);
    repeat (9) tick(1'b0, '0);
    chk("skip_absent", {31'b0, evrHeartbeat}, 32'd0);
    chk("skip_clear", {31'b0, csr.csrStatus[30]}, 32'd0);
    chk("skip_beat", {16'b0, beatCount}, 32'd3);
    repeat (10) tick(1'b0, '0);
    chk("skip_resume", {31'b0, evrHeartbeat}, 32'd1);
    chk("skip_beat4", {16'b0, beatCount}, 32'd4);

    // clamp and retune
    tick(1'b1, EN | 32'd1);
    chk("clamp_reload", {4'b0, csr.csrStatus[27:0]}, 32'd4);
    repeat (20) tick(1'b0, '0);
    tick(1'b1, EN | 32'd19);
    repeat (60) tick(1'b0, '0);
    tick(1'b1, EN | RST | 32'd19);
    wait_rise(k);
    chk("restart_gap", k, 32'd20);

    // single-shot while disabled
    tick(1'b1, 32'd9);
    repeat (2) tick(1'b0, '0);
    b = beatCount;
    tick(1'b1, SHOT | 32'd9);
    chk("shot_n", {31'b0, evrHeartbeat}, 32'd0);
    tick(1'b0, '0);
    chk("shot_n1", {31'b0, evrHeartbeat}, 32'd1);
    chk("shot_beat", {16'b0, beatCount}, {16'b0, b + 16'd1});
    repeat (3) tick(1'b0, '0);
    chk("shot_high4", {31'b0, evrHeartbeat}, 32'd1);
    tick(1'b0, '0);
    chk("shot_fall", {31'b0, evrHeartbeat}, 32'd0);

    // single-shot while enabled is ignored
    tick(1'b1, EN | SHOT | 32'd9);
    repeat (30) tick(1'b0, '0);

    // disable during the second high cycle
    wait_rise(k);
    tick(1'b0, '0);
    tick(1'b1, 32'd9);
    chk("dis_trunc", {31'b0, evrHeartbeat}, 32'd0);

    // async reset mid-pulse
    tick(1'b1, EN | 32'd9);
    wait_rise(k);
    tick(1'b0, '0);
    #2 evrReset = 1'b1;
    #1;
    chk("arst_hb", {31'b0, evrHeartbeat}, 32'd0);
    chk("arst_en", {31'b0, csr.csrStatus[31]}, 32'd0);
    model_reset();
    #3 evrReset = 1'b0;
    repeat (30) tick(1'b0, '0);

    // randomized CSR traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        d = '0;
        d[31] = ($urandom_range(0, 3) != 0);
        d[30] = ($urandom_range(0, 4) == 0);
        d[29] = ($urandom_range(0, 4) == 0);
        d[28] = ($urandom_range(0, 3) == 0);
        d[27:0] = 28'($urandom_range(0, 24));
        tick(1'b1, d);
      end else begin
        tick(1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/evr_heartbeat_gen.md
Name: evr_heartbeat_gen

Overview:
- Transmit end of the EVR heartbeat protocol: generates the periodic heartbeat pulse that the FA/SA acquisition synchronizers lock onto.
- Used on bench/loopback builds and as a local heartbeat source when no event receiver is fitted.
- Runs entirely in the EVR clock domain; control arrives as an already-synchronized CSR write strobe plus data word.
- Supports programmable period, fixed pulse width, one-pulse skip (to exercise loss-of-sync detection), single-shot pulse, and phase restart.

Parameters:
- BUS_WIDTH, 32, width of CSR data and status words.
- PERIOD_WIDTH, 28, width of the period reload field; must be <= BUS_WIDTH-4.
- PULSE_WIDTH, 4, heartbeat high time in evrClk cycles; >= 1.
- DEFAULT_RELOAD, 124999, reload value after reset (period = reload+1 cycles).

Ports:
- evrClk  in  1  EVR clock; all logic is on its rising edge.
- evrReset  in  1  reset, asynchronous, active-high.
- csrStrobe  in  1  single-cycle write enable, synchronous to evrClk.
- csrData  in  BUS_WIDTH  write word: [31] enable, [30] skip, [29] single-shot, [28] restart, [PERIOD_WIDTH-1:0] reload.
- csrStatus  out  BUS_WIDTH  {enabled, skipPending, evrHeartbeat, 1'b0, zeros, reload[PERIOD_WIDTH-1:0]}.
- evrHeartbeat  out  1  registered heartbeat pulse.
- beatCount  out  16  count of emitted pulses; wraps 0xFFFF->0.

Behaviour:
- Reset (async, active-high): enabled=0, counter=0, reload=DEFAULT_RELOAD, skipPending=0, evrHeartbeat=0, stretch=0, beatCount=0. Reset asserted mid-pulse drops evrHeartbeat immediately.
- Reload clamp: a written reload < PULSE_WIDTH is stored as PULSE_WIDTH. This guarantees at least one low cycle per period, so every pulse is a distinct rising edge.
- CSR write (csrStrobe=1, edge N):
  - reload is updated from the data word.
  - enabled <= bit31.
  - bit30=1 with bit31=1 sets skipPending.
  - bit31=0 clears skipPending.
- Enable 0->1 at edge N: counter <= the new reload. The first pulse rises at edge N+reload+1.
- Running state (enabled=1):
  - Each edge with counter != 0 decrements the counter.
  - On the edge where counter == 0, the counter is reloaded with the current reload.
  - On that same edge, if skipPending=0: evrHeartbeat <= 1, stretch <= PULSE_WIDTH-1, beatCount increments.
  - If skipPending=1 instead: no pulse is emitted, skipPending clears, and the counter still reloads, so phase is preserved.
- Period: rising edges are exactly reload+1 cycles apart.
- Pulse stretch: while stretch != 0, evrHeartbeat stays 1 and stretch decrements. When stretch == 0, evrHeartbeat returns to 0 on the following edge. High time is exactly PULSE_WIDTH cycles.
- Write while running, restart=0: the new reload is used at the next wrap. If the write lands on the wrap edge itself, the new value is the one loaded.
- Write while running, restart=1: counter <= the new reload at edge N. A pulse already in progress completes normally.
- Disable (bit31=0):
  - counter holds.
  - evrHeartbeat <= 0 at edge N, truncating any pulse in progress.
  - stretch <= 0.
- Single-shot (bit29=1):
  - Acted on only when enabled=0 after the write.
  - Pulse rises at edge N+1, is PULSE_WIDTH cycles wide, and increments beatCount.
  - Ignored if a pulse is already in progress or the block is enabled.
- Simultaneous write with enable and skip: the skip suppresses the first scheduled pulse.

Test Plan:
- Reset values: release reset -> evrHeartbeat=0, beatCount=0, csrStatus reload field=124999, bits[31:29]=0.
- Periodic output: write enable=1, reload=9 at edge N -> rising edges at N+10, N+20, N+30; each pulse 4 cycles high; beatCount=3 after the third pulse.
- Skip: running at reload=9, write enable+skip -> next expected pulse absent; the following pulse arrives on the original phase (20 cycles after the last pulse); skipPending reads 1 then 0; beatCount does not count the skipped pulse.
- Clamp and retune: write reload=1 -> status reads 4 and period is 5 cycles. Write reload=19 without restart mid-count -> the old period finishes, then 20-cycle periods. Write reload=19 with restart -> next edge 20 cycles after the write.
- Single-shot/disable: while disabled, write single-shot -> one 4-cycle pulse starting at N+1 and beatCount+1. While enabled, write single-shot -> no extra pulse. Disable during the 2nd high cycle -> heartbeat low on the next edge.
- Async reset mid-pulse: assert evrReset between clock edges while evrHeartbeat=1 -> output low immediately, enabled=0; after release no pulses until re-enabled.
